arm_mc_controller: RTL and testbench

Multicycle control unit for the ARMv4 subset (ADD, SUB, AND, ORR, TST, CMP, LSL, LDR, STR, B). It replaces single-cycle control so one shared memory and one ALU can be reused across an instruction. A main state machine drives the datapath's multiplexers and write enables cycle by cycle. The unit also contains ALU decode, the NZCV flag register, and condition evaluation.

---
 rtl/arm_mc_controller.sv | 175 +++++++++++++++++
 tb/tb_arm_mc_controller.sv | 170 +++++++++++++++++
 2 files changed

// File: rtl/arm_mc_controller.sv
// ============================================================================
// arm_mc_controller: multicycle ARMv4-subset control unit (FSM, ALU decode, NZCV, cond)
// Revision: 1.0
// ============================================================================
`default_nettype none

module arm_mc_controller (
  input  logic         clk,
  input  logic         reset,
  input  logic [31:12] Instr,
  input  logic [3:0]   ALUFlags,
  output logic         PCWrite,
  output logic         AdrSrc,
  output logic         MemWrite,
  output logic         IRWrite,
  output logic [1:0]   ResultSrc,
  output logic         ALUSrcA,
  output logic [1:0]   ALUSrcB,
  output logic [1:0]   ALUControl,
  output logic [1:0]   ImmSrc,
  output logic [1:0]   RegSrc,
  output logic         RegWrite,
  output logic         Shift,
  output logic [3:0]   State
);

  localparam logic [3:0] FETCH    = 4'd0;
  localparam logic [3:0] DECODE   = 4'd1;
  localparam logic [3:0] MEMADR   = 4'd2;
  localparam logic [3:0] MEMRD    = 4'd3;
  localparam logic [3:0] MEMWB    = 4'd4;
  localparam logic [3:0] MEMWR    = 4'd5;
  localparam logic [3:0] EXECUTER = 4'd6;
  localparam logic [3:0] EXECUTEI = 4'd7;
  localparam logic [3:0] ALUWB    = 4'd8;
  localparam logic [3:0] BRANCH   = 4'd9;

  logic [3:0] r_state, w_next;
  logic [3:0] r_flags;
  logic       r_condex, w_condex;
  logic [1:0] w_aluctl, w_flagw;
  logic       w_nowrite, w_shift, w_exec, w_regwrite, w_pcwrite, w_memwrite, w_irwrite;

  logic [3:0] w_cond;
  logic [1:0] w_op;
  logic [5:0] w_funct;
  logic [3:0] w_rd;
  logic       w_unused;

  assign w_cond   = Instr[31:28];
  assign w_op     = Instr[27:26];
  assign w_funct  = Instr[25:20];
  assign w_rd     = Instr[15:12];
  assign w_unused = &{1'b0, Instr[19:16]};

  assign ImmSrc = w_op;
  assign RegSrc = {(w_op == 2'b01) & ~w_funct[0], (w_op == 2'b10)};
  assign State  = r_state;

  // Condition check against the stored {N,Z,C,V}
  always_comb begin
    w_condex = 1'b0;
    case (w_cond)
      4'b0000: w_condex = r_flags[2];
      4'b0001: w_condex = ~r_flags[2];
      4'b0010: w_condex = r_flags[1];
      4'b0011: w_condex = ~r_flags[1];
      4'b0100: w_condex = r_flags[3];
      4'b0101: w_condex = ~r_flags[3];
      4'b0110: w_condex = r_flags[0];
      4'b0111: w_condex = ~r_flags[0];
      4'b1000: w_condex = r_flags[1] & ~r_flags[2];
      4'b1001: w_condex = ~r_flags[1] | r_flags[2];
      4'b1010: w_condex = (r_flags[3] == r_flags[0]);
      4'b1011: w_condex = (r_flags[3] != r_flags[0]);
      4'b1100: w_condex = ~r_flags[2] & (r_flags[3] == r_flags[0]);
      4'b1101: w_condex = r_flags[2] | (r_flags[3] != r_flags[0]);
      4'b1110: w_condex = 1'b1;
      default: w_condex = 1'b0;
    endcase
  end

  always_comb begin
    w_aluctl  = 2'b00;
    w_flagw   = 2'b00;
    w_nowrite = 1'b0;
    w_shift   = 1'b0;
    case (w_funct[4:1])
      4'b0100: begin w_aluctl = 2'b00; w_flagw = {w_funct[0], w_funct[0]}; end
      4'b0010: begin w_aluctl = 2'b01; w_flagw = {w_funct[0], w_funct[0]}; end
      4'b0000: begin w_aluctl = 2'b10; w_flagw = {w_funct[0], 1'b0}; end
      4'b1100: begin w_aluctl = 2'b11; w_flagw = {w_funct[0], 1'b0}; end
      4'b1000: begin w_aluctl = 2'b10; w_flagw = {w_funct[0], 1'b0}; w_nowrite = 1'b1; end
      4'b1010: begin w_aluctl = 2'b01; w_flagw = {w_funct[0], w_funct[0]}; w_nowrite = 1'b1; end
      4'b1101: begin w_aluctl = 2'b00; w_shift = 1'b1; end
      default: w_nowrite = 1'b1;
    endcase
  end

  assign w_exec = (r_state == EXECUTER) | (r_state == EXECUTEI) | (r_state == ALUWB);

  always_comb begin
    w_next = FETCH;
    case (r_state)
      FETCH:  w_next = DECODE;
      DECODE: begin
        case (w_op)
          2'b01:   w_next = MEMADR;
          2'b00:   w_next = w_funct[5] ? EXECUTEI : EXECUTER;
          2'b10:   w_next = BRANCH;
          default: w_next = FETCH;
        endcase
      end
      MEMADR:   w_next = w_funct[0] ? MEMRD : MEMWR;
      MEMRD:    w_next = MEMWB;
      EXECUTER: w_next = ALUWB;
      EXECUTEI: w_next = ALUWB;
      default:  w_next = FETCH;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state  <= FETCH;
      r_flags  <= 4'b0000;
      r_condex <= 1'b0;
    end else begin
      r_state <= w_next;
      if (r_state == DECODE)
        r_condex <= w_condex;
      // Flags commit at the end of execute, gated by this instruction's latched condition
      if (((r_state == EXECUTER) || (r_state == EXECUTEI)) && r_condex) begin
        if (w_flagw[1]) r_flags[3:2] <= ALUFlags[3:2];
        if (w_flagw[0]) r_flags[1:0] <= ALUFlags[1:0];
      end
    end
  end

  always_comb begin
    w_pcwrite  = 1'b0;
    AdrSrc     = 1'b0;
    w_memwrite = 1'b0;
    w_irwrite  = 1'b0;
    ResultSrc  = 2'b00;
    ALUSrcA    = 1'b0;
    ALUSrcB    = 2'b00;
    w_regwrite = 1'b0;
    case (r_state)
      FETCH: begin
        w_irwrite = 1'b1; ALUSrcA = 1'b1; ALUSrcB = 2'b10; ResultSrc = 2'b10; w_pcwrite = 1'b1;
      end
      DECODE:   begin ALUSrcA = 1'b1; ALUSrcB = 2'b10; ResultSrc = 2'b10; end
      MEMADR:   ALUSrcB = 2'b01;
      MEMRD:    AdrSrc = 1'b1;
      MEMWB:    begin ResultSrc = 2'b01; w_regwrite = r_condex; end
      MEMWR:    begin AdrSrc = 1'b1; w_memwrite = r_condex; end
      EXECUTEI: ALUSrcB = 2'b01;
      ALUWB:    w_regwrite = r_condex & ~w_nowrite;
      BRANCH:   begin ALUSrcB = 2'b01; ResultSrc = 2'b10; w_pcwrite = r_condex; end
      default:  ;
    endcase
    if (((r_state == MEMWB) || (r_state == ALUWB)) && (w_rd == 4'b1111))
      w_pcwrite = w_regwrite;
  end

  assign ALUControl = w_exec ? w_aluctl : 2'b00;
  assign Shift      = w_exec & w_shift;
  assign PCWrite    = w_pcwrite  & ~reset;
  assign IRWrite    = w_irwrite  & ~reset;
  assign RegWrite   = w_regwrite & ~reset;
  assign MemWrite   = w_memwrite & ~reset;

endmodule

`default_nettype wire

// File: tb/tb_arm_mc_controller.sv
// ============================================================================
// tb_arm_mc_controller: table-driven per-cycle check of the multicycle controller
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_arm_mc_controller;

  logic         clk = 1'b0;
  logic         reset;
  logic [31:12] Instr;
  logic [3:0]   ALUFlags;
  logic         PCWrite, AdrSrc, MemWrite, IRWrite, ALUSrcA, RegWrite, Shift;
  logic [1:0]   ResultSrc, ALUSrcB, ALUControl, ImmSrc, RegSrc;
  logic [3:0]   State;

  int n_cmp = 0;
  int n_bad = 0;

  arm_mc_controller dut (
    .clk(clk), .reset(reset), .Instr(Instr), .ALUFlags(ALUFlags),
    .PCWrite(PCWrite), .AdrSrc(AdrSrc), .MemWrite(MemWrite), .IRWrite(IRWrite),
    .ResultSrc(ResultSrc), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ALUControl(ALUControl),
    .ImmSrc(ImmSrc), .RegSrc(RegSrc), .RegWrite(RegWrite), .Shift(Shift), .State(State)
  );

  always #5 clk = ~clk;

  // {State,PCWrite,AdrSrc,MemWrite,IRWrite,ResultSrc,ALUSrcA,ALUSrcB,ALUControl,RegWrite,Shift,ImmSrc,RegSrc}
  typedef struct packed {
    logic        rst;
    logic [31:0] ins;
    logic [3:0]  fl;
    logic [20:0] exp;
  } vec_t;

  vec_t vq[$];

  function automatic logic [20:0] actual();
    return {State, PCWrite, AdrSrc, MemWrite, IRWrite, ResultSrc, ALUSrcA, ALUSrcB,
            ALUControl, RegWrite, Shift, ImmSrc, RegSrc};
  endfunction

  task automatic v(input logic [31:0] ins, input logic [3:0] fl, input logic [3:0] st,
                   input logic pcw, input logic adr, input logic mw, input logic irw,
                   input logic [1:0] rs, input logic sa, input logic [1:0] sb,
                   input logic [1:0] ac, input logic rw, input logic sh,
                   input logic [1:0] imm, input logic [1:0] rsrc);
    vec_t e;
    e.rst = 1'b0;
    e.ins = ins;
    e.fl  = fl;
    e.exp = {st, pcw, adr, mw, irw, rs, sa, sb, ac, rw, sh, imm, rsrc};
    vq.push_back(e);
  endtask

  task automatic fd(input logic [31:0] ins, input logic [3:0] fl,
                    input logic [1:0] imm, input logic [1:0] rsrc);
    v(ins, fl, 4'd0, 1, 0, 0, 1, 2'b10, 1, 2'b10, 2'b00, 0, 0, imm, rsrc);
    v(ins, fl, 4'd1, 0, 0, 0, 0, 2'b10, 1, 2'b10, 2'b00, 0, 0, imm, rsrc);
  endtask

  task automatic cyc(input string tag, input int idx, input logic rst, input logic [31:0] ins,
                     input logic [3:0] fl, input logic [20:0] exp);
    logic [20:0] act;
    @(negedge clk);
    reset    = rst;
    Instr    = ins[31:12];
    ALUFlags = fl;
    #1;
    act = actual();
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s[%0d] instr=%h outputs got=%b expected=%b", tag, idx, ins, act, exp);
    end
  endtask

  initial begin
    logic [3:0] en;
    reset = 1'b1; Instr = '0; ALUFlags = 4'b0000;

    // First reset cycle: state may be unknown, but write enables must be held low
    @(negedge clk); #1;
    en = {PCWrite, IRWrite, RegWrite, MemWrite};
    n_cmp++;
    if (en !== 4'b0000) begin
      n_bad++;
      $display("FAIL reset_enables got=%b expected=0000", en);
    end
    cyc("reset2", 0, 1'b1, 32'h0, 4'b0000,
        {4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b10, 1'b1, 2'b10, 2'b00, 1'b0, 1'b0, 2'b00, 2'b00});

    // ADD R0,R0,#5 (flags on bus must not be captured: S=0)
    fd(32'hE2800005, 4'b1011, 2'b00, 2'b00);
    v(32'hE2800005, 4'b1011, 4'd7, 0, 0, 0, 0, 2'b00, 0, 2'b01, 2'b00, 0, 0, 2'b00, 2'b00);
    v(32'hE2800005, 4'b1011, 4'd8, 0, 0, 0, 0, 2'b00, 0, 2'b00, 2'b00, 1, 0, 2'b00, 2'b00);
    // LDR
    fd(32'hE5901004, 4'b1011, 2'b01, 2'b00);
    v(32'hE5901004, 4'b1011, 4'd2, 0, 0, 0, 0, 2'b00, 0, 2'b01, 2'b00, 0, 0, 2'b01, 2'b00);
    v(32'hE5901004, 4'b1011, 4'd3, 0, 1, 0, 0, 2'b00, 0, 2'b00, 2'b00, 0, 0, 2'b01, 2'b00);
    v(32'hE5901004, 4'b1011, 4'd4, 0, 0, 0, 0, 2'b01, 0, 2'b00, 2'b00, 1, 0, 2'b01, 2'b00);
    // STR
    fd(32'hE5801004, 4'b1011, 2'b01, 2'b10);
    v(32'hE5801004, 4'b1011, 4'd2, 0, 0, 0, 0, 2'b00, 0, 2'b01, 2'b00, 0, 0, 2'b01, 2'b10);
    v(32'hE5801004, 4'b1011, 4'd5, 0, 1, 1, 0, 2'b00, 0, 2'b00, 2'b00, 0, 0, 2'b01, 2'b10);
    // CMP R0,R0 with Z on the bus -> flags 0100
    fd(32'hE1500000, 4'b0100, 2'b00, 2'b00);
    v(32'hE1500000, 4'b0100, 4'd6, 0, 0, 0, 0, 2'b00, 0, 2'b00, 2'b01, 0, 0, 2'b00, 2'b00);
    v(32'hE1500000, 4'b0100, 4'd8, 0, 0, 0, 0, 2'b00, 0, 2'b00, 2'b01, 0, 0, 2'b00, 2'b00);
    // BEQ taken
    fd(32'h0A000000, 4'b0000, 2'b10, 2'b01);
    v(32'h0A000000, 4'b0000, 4'd9, 1, 0, 0, 0, 2'b10, 0, 2'b01, 2'b00, 0, 0, 2'b10, 2'b01);
    // ADDNE with Z=1: full length, no write
    fd(32'h12800001, 4'b0000, 2'b00, 2'b00);
    v(32'h12800001, 4'b0000, 4'd7, 0, 0, 0, 0, 2'b00, 0, 2'b01, 2'b00, 0, 0, 2'b00, 2'b00);
    v(32'h12800001, 4'b0000, 4'd8, 0, 0, 0, 0, 2'b00, 0, 2'b00, 2'b00, 0, 0, 2'b00, 2'b00);
    // CMP clearing Z, then ADDNE now writes
    fd(32'hE1500000, 4'b0000, 2'b00, 2'b00);
    v(32'hE1500000, 4'b0000, 4'd6, 0, 0, 0, 0, 2'b00, 0, 2'b00, 2'b01, 0, 0, 2'b00, 2'b00);
    v(32'hE1500000, 4'b0000, 4'd8, 0, 0, 0, 0, 2'b00, 0, 2'b00, 2'b01, 0, 0, 2'b00, 2'b00);
    fd(32'h12800001, 4'b0000, 2'b00, 2'b00);
    v(32'h12800001, 4'b0000, 4'd7, 0, 0, 0, 0, 2'b00, 0, 2'b01, 2'b00, 0, 0, 2'b00, 2'b00);
    v(32'h12800001, 4'b0000, 4'd8, 0, 0, 0, 0, 2'b00, 0, 2'b00, 2'b00, 1, 0, 2'b00, 2'b00);
    // LSL R0,R0,#2 with Z on the bus: must not touch flags
    fd(32'hE1A00100, 4'b0100, 2'b00, 2'b00);
    v(32'hE1A00100, 4'b0100, 4'd6, 0, 0, 0, 0, 2'b00, 0, 2'b00, 2'b00, 0, 1, 2'b00, 2'b00);
    v(32'hE1A00100, 4'b0100, 4'd8, 0, 0, 0, 0, 2'b00, 0, 2'b00, 2'b00, 1, 1, 2'b00, 2'b00);
    // BEQ not taken (Z still 0)
    fd(32'h0A000000, 4'b0000, 2'b10, 2'b01);
    v(32'h0A000000, 4'b0000, 4'd9, 0, 0, 0, 0, 2'b10, 0, 2'b01, 2'b00, 0, 0, 2'b10, 2'b01);
    // ADD R15,R0,#5: PC written alongside the register write
    fd(32'hE280F005, 4'b0000, 2'b00, 2'b00);
    v(32'hE280F005, 4'b0000, 4'd7, 0, 0, 0, 0, 2'b00, 0, 2'b01, 2'b00, 0, 0, 2'b00, 2'b00);
    v(32'hE280F005, 4'b0000, 4'd8, 1, 0, 0, 0, 2'b00, 0, 2'b00, 2'b00, 1, 0, 2'b00, 2'b00);
    // Undefined op: two cycles, back to FETCH
    fd(32'hEC000000, 4'b0000, 2'b11, 2'b00);
    // CMP setting Z again, so the post-reset check below proves the flags were cleared
    fd(32'hE1500000, 4'b0100, 2'b00, 2'b00);
    v(32'hE1500000, 4'b0100, 4'd6, 0, 0, 0, 0, 2'b00, 0, 2'b00, 2'b01, 0, 0, 2'b00, 2'b00);
    v(32'hE1500000, 4'b0100, 4'd8, 0, 0, 0, 0, 2'b00, 0, 2'b00, 2'b01, 0, 0, 2'b00, 2'b00);
    // STR start; the MEMWR cycle is hit by reset in the hand sequence below
    fd(32'hE5801004, 4'b0000, 2'b01, 2'b10);
    v(32'hE5801004, 4'b0000, 4'd2, 0, 0, 0, 0, 2'b00, 0, 2'b01, 2'b00, 0, 0, 2'b01, 2'b10);

    foreach (vq[i])
      cyc("vec", i, vq[i].rst, vq[i].ins, vq[i].fl, vq[i].exp);

    // Reset during MEMWR: no write that cycle, FETCH next
    cyc("rst_memwr", 0, 1'b1, 32'hE5801004, 4'b0000,
        {4'd5, 1'b0, 1'b1, 1'b0, 1'b0, 2'b00, 1'b0, 2'b00, 2'b00, 1'b0, 1'b0, 2'b01, 2'b10});
    cyc("rst_memwr", 1, 1'b0, 32'h05801004, 4'b0000,
        {4'd0, 1'b1, 1'b0, 1'b0, 1'b1, 2'b10, 1'b1, 2'b10, 2'b00, 1'b0, 1'b0, 2'b01, 2'b10});
    // STREQ after reset: Z cleared, so the store is suppressed but the length is kept
    cyc("streq", 0, 1'b0, 32'h05801004, 4'b0000,
        {4'd1, 1'b0, 1'b0, 1'b0, 1'b0, 2'b10, 1'b1, 2'b10, 2'b00, 1'b0, 1'b0, 2'b01, 2'b10});
    cyc("streq", 1, 1'b0, 32'h05801004, 4'b0000,
        {4'd2, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 2'b01, 2'b00, 1'b0, 1'b0, 2'b01, 2'b10});
    cyc("streq", 2, 1'b0, 32'h05801004, 4'b0000,
        {4'd5, 1'b0, 1'b1, 1'b0, 1'b0, 2'b00, 1'b0, 2'b00, 2'b00, 1'b0, 1'b0, 2'b01, 2'b10});
    cyc("streq", 3, 1'b0, 32'h05801004, 4'b0000,
        {4'd0, 1'b1, 1'b0, 1'b0, 1'b1, 2'b10, 1'b1, 2'b10, 2'b00, 1'b0, 1'b0, 2'b01, 2'b10});

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

`default_nettype wire
